i2c_bus_arbiter: RTL

Shares the single local I2C master engine among NREQ requesters with round-robin priority. Admits a requester only after the bus has been idle for the bus-free time, holds the grant through the transfer, and reclaims it after the requester releases and the bus goes idle again. Sits between the requesting clients and the I2C master and consumes `bby`/`sto` from the bus-busy detector.

---
 rtl/i2c_bus_arbiter_pkg.sv | 17 +
 rtl/i2c_bus_arbiter_rr_pick.sv | 41 ++++
 rtl/i2c_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_bus_arbiter_pkg
//   Shared definitions for the I2C bus arbiter: FSM state encodings and
//   counter widths. Imported by i2c_bus_arbiter and i2c_rr_pick.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        GRANT     = 2'd2,
        DRAIN     = 2'd3
    } arb_state_t;

    localparam int FREE_W = 16;  // bus-free counter width
    localparam int HOLD_W = 32;  // grant-hold watchdog counter width
    localparam int ID_W   = 3;   // client index width (NREQ <= 8)

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// i2c_rr_pick
//   Combinational round-robin picker. Returns the first set request bit at
//   or above ptr, wrapping modulo NREQ.
//   Ports:
//     req  in  NREQ  request vector
//     ptr  in  3     starting index for the search (0..NREQ-1)
//     any  out 1     at least one request is set
//     idx  out 3     index of the winner (0 when any=0)
module i2c_rr_pick
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W:0]     sum;

    // Rotate so that bit 0 of rot is client ptr, then scan downward so the
    // lowest rotated position (closest to ptr) is the last one to assign idx.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        any = |rot;
        idx = '0;
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NREQ))
                sum = sum - (ID_W + 1)'(NREQ);
            if (rot[k])
                idx = sum[ID_W-1:0];
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
//   Shares one local I2C master engine among NREQ requesters, round-robin.
//   A client is admitted only after the bus has been idle (bby=0) for BUF_CYC
//   cycles; the grant is held while its req stays high and is reclaimed once
//   req drops and the bus goes idle again (STOP seen or bby low).
//   Optional feature macro: I2C_ARB_TIMEOUT_EN enables a grant-hold watchdog
//   that revokes a grant after TMO_CYC cycles and pulses tmo.
//   Ports:
//     clk     in  1     system clock, rising edge
//     rst     in  1     asynchronous active-high reset
//     req     in  NREQ  level request per client
//     bby     in  1     bus busy
//     sto     in  1     STOP-detected pulse
//     lost    in  1     arbitration-lost pulse from the master engine
//     gnt     out NREQ  one-hot registered grant
//     gnt_id  out 3     index of the granted client (valid while own=1)
//     own     out 1     local master owns the bus
//     tmo     out 1     watchdog revoke pulse (0 without the macro)
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BUF_CYC  = 600,
    parameter int TMO_CYC  = 1000000,
    parameter int US       = 100,  // passthrough, shared with bus-busy detector
    parameter int I2C_MODE = 0     // passthrough, shared with bus-busy detector
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            bby,
    input  logic            sto,
    input  logic            lost,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            own,
    output logic            tmo
);

    if (NREQ < 2 || NREQ > 8 || BUF_CYC < 1 || BUF_CYC > 65535 ||
        TMO_CYC < 1 || US < 0 || I2C_MODE < 0) begin : g_bad_cfg
        $error("i2c_bus_arbiter: parameter out of range");
    end

    localparam logic [FREE_W-1:0] BUF_LD = FREE_W'(BUF_CYC);
    localparam logic [ID_W-1:0]   LAST   = ID_W'(NREQ - 1);

    arb_state_t        state, state_n;
    logic [FREE_W-1:0] cnt, cnt_n;
    logic [ID_W-1:0]   ptr, ptr_n;
    logic [NREQ-1:0]   gnt_n;
    logic [ID_W-1:0]   gnt_id_n;
    logic              own_n;
    logic [NREQ-1:0]   req_eff;
    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold, hold_n;
    logic [NREQ-1:0]   ban, ban_n;   // offenders locked out until they drop req
    logic              tmo_n;
    assign req_eff = req & ~ban;
`else
    assign req_eff = req;
    assign tmo     = 1'b0;
`endif

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_eff),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            own    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            hold   <= '0;
            ban    <= '0;
            tmo    <= 1'b0;
`endif
        end else begin
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            own    <= own_n;
`ifdef I2C_ARB_TIMEOUT_EN
            hold   <= hold_n;
            ban    <= ban_n;
            tmo    <= tmo_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        own_n    = own;
`ifdef I2C_ARB_TIMEOUT_EN
        hold_n   = hold;
        ban_n    = ban & req;   // a ban clears once the client drops req
        tmo_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req_eff) begin
                    state_n = WAIT_FREE;
                    cnt_n   = BUF_LD;
                end
            end
            WAIT_FREE: begin
                if (!(|req_eff)) begin
                    state_n = IDLE;
                end else if (bby) begin
                    cnt_n = BUF_LD;
                end else if (cnt == '0) begin
                    state_n  = GRANT;
                    gnt_n    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    gnt_id_n = pick_idx;
                    own_n    = pick_any;
                    ptr_n    = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    hold_n   = '0;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GRANT: begin
                // lost outranks release: retry the same client first
                if (lost) begin
                    state_n  = WAIT_FREE;
                    cnt_n    = BUF_LD;
                    ptr_n    = gnt_id;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    own_n    = 1'b0;
                end else if (!(|(req & gnt))) begin
                    state_n  = DRAIN;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    own_n    = 1'b0;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (hold == HOLD_W'(TMO_CYC - 1)) begin
                    // ptr already points past the offender, so it loses priority
                    state_n  = DRAIN;
                    ban_n    = ban_n | gnt;
                    tmo_n    = 1'b1;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    own_n    = 1'b0;
                end else begin
                    hold_n = hold + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (sto || !bby)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
